// File: rtl/stage_ctrl_pkg.sv
// stage_ctrl shared codes: state-machine stage codes and controller states.
// Helper is_stage() flags codes that own a datapath unit.
package stage_ctrl_pkg;

  localparam int STATE_LEN = 4;
  localparam int CTRL_LEN  = 3;

  typedef logic [STATE_LEN-1:0] code_t;

  localparam code_t IDLE = 4'd0;
  localparam code_t RECV = 4'd1;
  localparam code_t EMB  = 4'd2;
  localparam code_t MIX1 = 4'd3;
  localparam code_t MIX2 = 4'd4;
  localparam code_t MIX3 = 4'd5;
  localparam code_t DENS = 4'd6;
  localparam code_t COMP = 4'd7;
  localparam code_t SEND = 4'd8;

  typedef enum logic [CTRL_LEN-1:0] {
    C_IDLE   = 3'd0,
    C_ADV    = 3'd1,
    C_SETTLE = 3'd2,
    C_START  = 3'd3,
    C_WAIT   = 3'd4,
    C_ABORT  = 3'd5
  } ctrl_t;

  function automatic logic is_stage(code_t c);
    return (c >= RECV) && (c <= SEND);
  endfunction

endpackage

// File: rtl/stage_ctrl_timer.sv
// stage_timer: watchdog counter (load to 0, count on en, expired at LIMIT-1).
// Ports: clk, rst_n, load, en -> expired. Used only with STAGE_TIMEOUT_EN.
module stage_timer #(
  parameter int W     = 21,
  parameter int LIMIT = 1048576
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (load) cnt <= '0;
    else if (en)   cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/stage_ctrl.sv
// stage_ctrl: sequences run/set of the inference state machine, strobes
// unit starts and waits for done. Ports: clk, rst_n, go, clr, state,
// *_done in; run, set, d, *_start, mix_sel, busy, fin, err out.
// Macro STAGE_TIMEOUT_EN adds a per-stage watchdog abort.
module stage_ctrl
  import stage_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int TMR_W          = 21
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 go,
  input  logic                 clr,
  input  logic [STATE_LEN-1:0] state,
  input  logic                 recv_done,
  input  logic                 emb_done,
  input  logic                 mix_done,
  input  logic                 dens_done,
  input  logic                 comp_done,
  input  logic                 send_done,
  output logic                 run,
  output logic                 set,
  output logic [STATE_LEN-1:0] d,
  output logic                 recv_start,
  output logic                 emb_start,
  output logic                 mix_start,
  output logic                 dens_start,
  output logic                 comp_start,
  output logic                 send_start,
  output logic [1:0]           mix_sel,
  output logic                 busy,
  output logic                 fin,
  output logic                 err
);

  if (TIMEOUT_CYCLES > (1 << TMR_W)) begin : g_bad_cfg
    $error("TMR_W too narrow for TIMEOUT_CYCLES");
  end

  ctrl_t cs, ns;
  logic  act_done;
  logic  tmo;
  logic  in_start;

  always_comb begin
    act_done = 1'b0;
    unique case (1'b1)
      (state == RECV): act_done = recv_done;
      (state == EMB):  act_done = emb_done;
      (state == MIX1),
      (state == MIX2),
      (state == MIX3): act_done = mix_done;
      (state == DENS): act_done = dens_done;
      (state == COMP): act_done = comp_done;
      (state == SEND): act_done = send_done;
      default:         act_done = 1'b0;
    endcase
  end

`ifdef STAGE_TIMEOUT_EN
  stage_timer #(
    .W     (TMR_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_tmr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (cs == C_START),
    .en      (cs == C_WAIT),
    .expired (tmo)
  );
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cs <= C_IDLE;
    else        cs <= ns;
  end

  always_comb begin
    ns = cs;
    unique case (cs)
      C_IDLE:   if (go && state == IDLE) ns = C_ADV;
      C_ADV:    ns = C_SETTLE;
      C_SETTLE: begin
        if (state == IDLE)        ns = C_IDLE;
        else if (is_stage(state)) ns = C_START;
        else                      ns = C_ABORT;
      end
      C_START:  ns = C_WAIT;
      // a done on the expiry cycle still advances
      C_WAIT: begin
        if (act_done) ns = C_ADV;
        else if (tmo) ns = C_ABORT;
      end
      C_ABORT:  ns = C_IDLE;
      default:  ns = C_IDLE;
    endcase
  end

  // only C_WAIT/C_SETTLE lead to C_ABORT, so this is the entry edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              err <= 1'b0;
    else if (ns == C_ABORT)  err <= 1'b1;
    else if (clr)            err <= 1'b0;
  end

  assign in_start   = (cs == C_START);
  assign run        = (cs == C_ADV);
  assign set        = (cs == C_ABORT);
  assign d          = IDLE;
  assign busy       = (cs != C_IDLE);
  assign fin        = (cs == C_SETTLE) && (state == IDLE);
  assign recv_start = in_start && (state == RECV);
  assign emb_start  = in_start && (state == EMB);
  assign mix_start  = in_start &&
                      (state == MIX1 || state == MIX2 ||
                       state == MIX3);
  assign dens_start = in_start && (state == DENS);
  assign comp_start = in_start && (state == COMP);
  assign send_start = in_start && (state == SEND);

  always_comb begin
    mix_sel = 2'd0;
    unique case (1'b1)
      (state == MIX2): mix_sel = 2'd1;
      (state == MIX3): mix_sel = 2'd2;
      default:         mix_sel = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_stage_ctrl.sv
// tb_stage_ctrl: drives stage_ctrl against a stage-advancing state machine
// and random-latency units; expected timeline computed per sequence.
module tb_stage_ctrl;
  import stage_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic go = 1'b0;
  logic clr = 1'b0;
  logic [5:0] dn = '0;
  logic [STATE_LEN-1:0] st, state, d;
  logic [STATE_LEN-1:0] force_code = '0;
  logic force_en = 1'b0;
  logic run, set, busy, fin, err;
  logic recv_start, emb_start, mix_start;
  logic dens_start, comp_start, send_start;
  logic [1:0] mix_sel;

  int vecs = 0;
  int bad = 0;
  int cyc_n = 0;
  logic err_exp = 1'b0;

  always #5 clk = ~clk;

  assign state = force_en ? force_code : st;

  // inference state machine: one-cycle registration of run/set
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)   st <= IDLE;
    else if (set) st <= d;
    else if (run) st <= (st == SEND) ? IDLE : st + 4'd1;
  end

  stage_ctrl #(
    .TIMEOUT_CYCLES (16),
    .TMR_W          (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .go         (go),
    .clr        (clr),
    .state      (state),
    .recv_done  (dn[0]),
    .emb_done   (dn[1]),
    .mix_done   (dn[2]),
    .dens_done  (dn[3]),
    .comp_done  (dn[4]),
    .send_done  (dn[5]),
    .run        (run),
    .set        (set),
    .d          (d),
    .recv_start (recv_start),
    .emb_start  (emb_start),
    .mix_start  (mix_start),
    .dens_start (dens_start),
    .comp_start (comp_start),
    .send_start (send_start),
    .mix_sel    (mix_sel),
    .busy       (busy),
    .fin        (fin),
    .err        (err)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    vecs++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_run,
                            input logic e_set, input logic [5:0] e_st,
                            input logic [1:0] e_ms, input logic e_fin,
                            input logic e_busy);
    chk({tag, ".run"}, 8'(run), 8'(e_run));
    chk({tag, ".set"}, 8'(set), 8'(e_set));
    chk({tag, ".starts"},
        8'({send_start, comp_start, dens_start,
            mix_start, emb_start, recv_start}), 8'(e_st));
    chk({tag, ".mix_sel"}, 8'(mix_sel), 8'(e_ms));
    chk({tag, ".fin"}, 8'(fin), 8'(e_fin));
    chk({tag, ".busy"}, 8'(busy), 8'(e_busy));
    chk({tag, ".d"}, 8'(d), 8'(IDLE));
    chk({tag, ".err"}, 8'(err), 8'(err_exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      check_outs("idle", 0, 0, '0, 2'd0, 0, 0);
    end
  endtask

  // stage index 0..7 -> unit bit (recv,emb,mix,dens,comp,send)
  function automatic int unit_of(input int i);
    if (i <= 1) return i;
    if (i <= 4) return 2;
    return i - 2;
  endfunction

  // stall>=0: that stage never completes (timeout, or reset if do_rst)
  task automatic run_seq(input bit hold_go, input int stall,
                         input bit do_rst);
    int g, endc, last, c, a, u;
    int s[8];
    int m[8];
    logic [5:0] e_st;
    logic [1:0] e_ms;
    logic e_run, e_fin, e_busy, e_set;
    g = cyc_n;
    go = 1'b1;
    s[0] = g + 3;
    for (int i = 0; i < 8; i++) begin
      m[i] = s[i] + ((i == 1) ? int'($urandom_range(3, 6))
                              : int'($urandom_range(1, 6)));
      if (i < 7) s[i+1] = m[i] + 3;
    end
    last = (stall >= 0) ? stall : 7;
    a = (stall >= 0) ? s[last] + 17 : -1;
    if (do_rst)          endc = s[last] + 2;
    else if (stall >= 0) endc = a + 1;
    else                 endc = m[7] + 3;
    while (cyc_n < endc) begin
      tick();
      c = cyc_n;
      if (!hold_go) go = 1'b0;
      dn = '0;
      for (int i = 0; i <= last; i++) begin
        if (c == m[i] && i != stall) dn[unit_of(i)] = 1'b1;
        else if (c > s[i] &&
                 c < ((i == stall) ? a : m[i]) &&
                 $urandom_range(0, 3) == 0) begin
          u = int'($urandom_range(0, 5));
          if (u != unit_of(i)) dn[u] = 1'b1;
        end
      end
      if (last >= 1 && c == s[1] + 1) dn[4] = 1'b1;
      e_run = (c == g + 1);
      e_st = '0;
      e_ms = 2'd0;
      e_fin = (stall < 0) && (c == m[7] + 2);
      for (int i = 0; i <= last; i++) begin
        if (i != stall && c == m[i] + 1) e_run = 1'b1;
        if (c == s[i]) e_st[unit_of(i)] = 1'b1;
        if (i >= 2 && i <= 4 && c >= s[i] - 1 &&
            c <= ((i == stall) ? a : m[i] + 1))
          e_ms = 2'(i - 2);
      end
      e_set = (stall >= 0) && !do_rst && (c == a);
      if (e_set) err_exp = 1'b1;
      e_busy = (c >= g + 1) &&
               (c <= ((stall < 0) ? m[7] + 2 : a));
      check_outs("seq", e_run, e_set, e_st, e_ms, e_fin, e_busy);
    end
    dn = '0;
    if (do_rst) begin
      #1 rst_n = 1'b0;
      err_exp = 1'b0;
      #1;
      check_outs("rst", 0, 0, '0, 2'd0, 0, 0);
      #2 rst_n = 1'b1;
      go = 1'b0;
      idle(10);
    end
  endtask

  task automatic bad_code(input bit with_clr);
    go = 1'b1;
    tick();
    go = 1'b0;
    check_outs("bad.adv", 1, 0, '0, 2'd0, 0, 1);
    tick();
    force_en = 1'b1;
    force_code = 4'($urandom_range(9, 15));
    clr = with_clr;
    check_outs("bad.settle", 0, 0, '0, 2'd0, 0, 1);
    tick();
    force_en = 1'b0;
    clr = 1'b0;
    err_exp = 1'b1;
    check_outs("bad.abort", 0, 1, '0, 2'd0, 0, 1);
    tick();
    check_outs("bad.after", 0, 0, '0, 2'd0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0;
    #2;
    check_outs("reset", 0, 0, '0, 2'd0, 0, 0);
    #10 rst_n = 1'b1;
    idle(3);
    run_seq(0, -1, 0);
    idle(2);
    run_seq(1, -1, 0);
    run_seq(0, -1, 0);
    idle(2);
    run_seq(0, -1, 0);
    idle(1);
`ifdef STAGE_TIMEOUT_EN
    run_seq(0, 5, 0);
    idle(4);
`endif
    bad_code(0);
    idle(3);
    bad_code(1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    err_exp = 1'b0;
    check_outs("clr", 0, 0, '0, 2'd0, 0, 0);
    idle(2);
    run_seq(0, 3, 1);
    run_seq(0, -1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end

endmodule

// File: doc/stage_ctrl.md
# stage_ctrl

Stage controller driving the top-level inference state machine's `run`/`set` inputs. Watches the current state code, issues one-cycle start strobes to the matching datapath unit (receiver, embedding, mixer ×3, dense, comparator, sender), waits for that unit's done, then advances the state machine. Optionally aborts a stalled stage back to IDLE via a watchdog.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1048576: maximum cycles a stage may stay in WAIT.
- `TMR_W`, default 21: watchdog counter width. It must satisfy 2^TMR_W ≥ TIMEOUT_CYCLES.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `go`  in  1  start request; honoured only while idle
- `clr`  in  1  synchronous clear of `err`
- `state`  in  `STATE_LEN`  current state-machine output
- `recv_done`, `emb_done`, `mix_done`, `dens_done`, `comp_done`, `send_done`  in  1 each  unit completion pulses
- `run`  out  1  advance strobe to the state machine
- `set`  out  1  forced-load strobe to the state machine
- `d`  out  `STATE_LEN`  forced-load value; always `IDLE`
- `recv_start`, `emb_start`, `mix_start`, `dens_start`, `comp_start`, `send_start`  out  1 each  unit start strobes
- `mix_sel`  out  2  mixer layer: 0/1/2 for MIX1/MIX2/MIX3
- `busy`  out  1  a sequence is in progress
- `fin`  out  1  one-cycle pulse when the sequence returns to IDLE
- `err`  out  1  sticky abort flag

## Operation
- Controller FSM states: C_IDLE, C_ADV, C_SETTLE, C_START, C_WAIT, C_ABORT.
- Outputs are Moore decodes of the registered controller state, with `state` gating the start strobes. `err` is a register.
- **C_IDLE:** if `go` and `state`==IDLE, go to C_ADV. Otherwise stay.
- **C_ADV:** `run`=1 for one cycle, then C_SETTLE.
- **C_SETTLE:**
  - `state`==IDLE: `fin`=1, go to C_IDLE.
  - Valid stage code: go to C_START.
  - Any other code: go to C_ABORT.
- **C_START:** assert the start strobe of the unit selected by `state` for one cycle, then C_WAIT. MIX1/MIX2/MIX3 all use `mix_start`.
- **C_WAIT:** go to C_ADV on the done input of the active unit only. `mix_done` counts for any MIX state. Done inputs of other units are ignored.
- Done is sampled only in C_WAIT. Units must pulse done no earlier than the cycle after start; a done during C_START is lost.
- **C_ABORT:** `set`=1 and `d`=IDLE for one cycle. `err` is set on the edge into C_ABORT. Then C_IDLE.
- `go` while not in C_IDLE is ignored. `go` in C_IDLE while `state`≠IDLE is ignored.
- `err` clears on `clr`. If `clr` and a new abort occur in the same cycle, set wins.
- `mix_sel` decodes `state` combinationally and is stable from C_START through C_WAIT. It is 0 outside the MIX states.
- `busy` = (controller state ≠ C_IDLE).
- Reset values: controller state C_IDLE; `run`, `set`, all start strobes, `busy`, `fin`, `err` = 0; `mix_sel`=0; `d`=IDLE. Reset mid-sequence returns to C_IDLE with no strobes.

## Timing
- `go` sampled at edge n: `run` high in cycle n+1; `state`=RECV and C_SETTLE in n+2; `recv_start` in n+3; C_WAIT from n+4.
- Done in cycle m: `run` in m+1, settle in m+2, next start in m+3. Inter-stage overhead is 3 cycles.
- SEND done in cycle m: `run` in m+1, `state`=IDLE and `fin`=1 in m+2, `busy`=0 in m+3.
- The state machine must register `run`/`set` in one cycle. The single-cycle settle relies on this.

## Configuration
- `STAGE_TIMEOUT_EN` defined:
  - The watchdog loads 0 in C_START and increments each C_WAIT cycle.
  - If the counter equals TIMEOUT_CYCLES−1 in C_WAIT with no active done, next state is C_ABORT.
  - A done on that same cycle wins and goes to C_ADV.
- Undefined: no counter. C_WAIT waits indefinitely. C_ABORT is reachable only via an invalid state code.

## Structure
- `consts.vh` holds `STATE_LEN` and the state codes (existing), plus new `CTRL_LEN` and the `C_*` controller codes.
- Sub-module `stage_timer`: counter with load, enable and `expired` output. It is instantiated only under `STAGE_TIMEOUT_EN`.

## Test plan
- Full run: `go` pulse; every unit pulses done 5 cycles after its start. Expect 8 start strobes in order RECV, EMB, MIX×3 (`mix_sel` 0,1,2), DENS, COMP, SEND. Expect exactly 9 `run` pulses, 1 `fin`, and `err`=0.
- Spurious done: `comp_done` pulsed while waiting in EMB → no `run`. Then `emb_done` → `run` exactly 1 cycle later.
- Go while busy: `go` held high through the whole sequence → after `fin`, a new sequence starts with `run` 1 cycle after C_IDLE is re-entered.
- Timeout (macro on, TIMEOUT_CYCLES=16): DENS never completes → `set`=1 and `d`=IDLE exactly 16 cycles after C_WAIT entry. `err`=1 until `clr`. The `clr`+abort collision keeps `err`=1.
- Invalid code: force `state` to an unused code in C_SETTLE → C_ABORT, `set` pulse, `err`=1.
- Reset mid-WAIT in MIX2: all outputs return to reset values immediately. After release there are no strobes until `go`.
